uc_microc_param: RTL and testbench
==================================

Name: uc_microc_param

Overview:
- Parametrised, sequential control unit for the microc single-cycle CPU; successor of the purely combinational opcode decoder.
- Decodes Opcode and z into datapath controls (s_inc, s_inm, we3, wez, Op).
- Adds a PC write-enable/stall input, call/return via an internal return-address stack, a halt instruction, and a fault state for illegal opcodes and stack misuse.
- Sits between the instruction memory opcode field and the microc datapath.

Parameters:
- OPW, 6, opcode width (bits). Encodings below use the top 6 bits.
- ALUW, 3, ALU operation width; Op = Opcode[ALUW+1:2].
- PC_W, 10, program counter width.
- STACK_DEPTH, 4, return-address stack entries (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable. 0 = stall: no architectural writes.
- Opcode  in  OPW  current instruction opcode.
- z  in  1  zero flag from datapath.
- pc_next  in  PC_W  PC+1 from datapath; pushed on jal.
- s_inc  out  1  PC mux: 1 = PC+1, 0 = jump target.
- s_inm  out  1  register-file write-data mux: 1 = immediate.
- we3  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- Op  out  ALUW  ALU operation.
- pc_we  out  1  PC load enable.
- s_ret  out  1  1 = PC loads ret_addr; overrides s_inc.
- ret_addr  out  PC_W  top of the return stack.
- halted  out  1  state == HALT.
- fault  out  1  state == FAULT.
- sp  out  $clog2(STACK_DEPTH+1)  stack occupancy.
- icount  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- States: RUN, HALT, FAULT.
- Reset (sync): state = RUN, sp = 0, icount = 0, stack contents don't-care.
- Control outputs are combinational from state, Opcode and z. Register updates happen on the rising edge of clk.

Opcode decode in RUN with en = 1. All listed instructions set pc_we = 1; unlisted signals are 0.
- 1xxxxx ALU: s_inc = 1, we3 = 1, wez = 1, Op = Opcode[4:2].
- 000000 nop: s_inc = 1.
- 0001xx li: s_inc = 1, s_inm = 1, we3 = 1.
- 010000 j: s_inc = 0.
- 010001 jz: s_inc = ~z.
- 010010 jnz: s_inc = z.
- 010011 jal: s_inc = 0. On the clock edge: stack[sp] <= pc_next, sp <= sp+1.
- 010100 ret: s_ret = 1. On the clock edge: sp <= sp-1.
- 011111 halt: pc_we = 0, next state = HALT.
- Any other opcode: pc_we = 0, next state = FAULT.

Stack and flag rules:
- ret_addr = stack[sp-1] when sp > 0, else 0.
- jal with sp == STACK_DEPTH: no push, pc_we = 0, next state = FAULT.
- ret with sp == 0: pc_we = 0, next state = FAULT.
- Jumps never write z. The jz/jnz decision uses the z value present in the same cycle.

en = 0 (any state): all write enables (pc_we, we3, wez) are 0. No stack, sp, state or icount change. s_inc, s_inm and Op still reflect decode.

HALT and FAULT:
- pc_we = we3 = wez = 0, s_ret = 0.
- Held until reset; Opcode is ignored.

Reset has priority over every event, including a jal or ret in the same cycle.

Optional Feature:
- Macro: UC_ICOUNT_EN.
- Defined: icount increments by 1 on every edge where state == RUN, en = 1 and pc_we = 1. Wraps at 2^32.
- Undefined: icount is tied to 0 and no counter register is built.

Decomposition:
- Package microc_pkg holds:
  - opcode constants: OP_NOP, OP_LI, OP_J, OP_JZ, OP_JNZ, OP_JAL, OP_RET, OP_HALT, ALU prefix;
  - the state type (RUN, HALT, FAULT);
  - ALU Op encodings.
- One sub-module, pila_retorno, parametrised by PC_W and STACK_DEPTH:
  - ports: push, pop, din, top, sp, full, empty;
  - the control unit gates push/pop with the fault checks.

Test Plan:
- Reset held 2 cycles, then Opcode = 100100 with en = 1 → s_inc = 1, we3 = 1, wez = 1, Op = 001, pc_we = 1, sp = 0, halted = 0, fault = 0.
- jz with z = 1 → s_inc = 0. jz with z = 0 → s_inc = 1. jnz with z = 1 → s_inc = 1. All cases wez = 0.
- jal, pc_next = 0x005, then jal, pc_next = 0x0A1 → sp = 2, ret_addr = 0x0A1. Next ret → s_ret = 1, ret_addr = 0x0A1, then sp = 1 and ret_addr = 0x005.
- STACK_DEPTH = 4: five consecutive jal → fourth leaves sp = 4. Fifth: pc_we = 0, fault = 1 the next cycle, sp stays 4. fault holds until reset; reset → RUN, sp = 0.
- ret at sp = 0 → fault = 1. Separately, opcode 001000 → fault = 1. Separately, 011111 → halted = 1, and later ALU opcodes give we3 = 0, pc_we = 0.
- en = 0 during li → we3 = 0, pc_we = 0, s_inm = 1, state and sp unchanged.
  - With UC_ICOUNT_EN: 10 RUN instructions with en = 1 plus 3 stalled cycles → icount = 10.
  - Without the macro: icount = 0.

Source files
------------

// File: rtl/uc_microc_param_pkg.sv
// microc control unit: shared opcode constants, FSM state and ALU op types.
package microc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASSA = 3'd0,
        ALU_NOTA  = 3'd1,
        ALU_ADD   = 3'd2,
        ALU_SUB   = 3'd3,
        ALU_AND   = 3'd4,
        ALU_OR    = 3'd5,
        ALU_NEGA  = 3'd6,
        ALU_NEGB  = 3'd7
    } alu_op_t;

    localparam logic       OP_ALU_PFX = 1'b1;
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_LI   = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_JAL  = 6'b010011;
    localparam logic [5:0] OP_RET  = 6'b010100;
    localparam logic [5:0] OP_HALT = 6'b011111;

    // li carries a 2-bit don't-care field in its low bits
    function automatic logic is_li_op(input logic [5:0] op);
        return op[5:2] == OP_LI[5:2];
    endfunction

endpackage

// File: rtl/uc_microc_param_if.sv
// microc control unit bus: datapath inputs and decoded control outputs.
interface uc_microc_param_if #(
    parameter int OPW         = 6,
    parameter int ALUW        = 3,
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) ();
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    logic            en;
    logic [OPW-1:0]  Opcode;
    logic            z;
    logic [PC_W-1:0] pc_next;

    logic            s_inc;
    logic            s_inm;
    logic            we3;
    logic            wez;
    logic [ALUW-1:0] Op;
    logic            pc_we;
    logic            s_ret;
    logic [PC_W-1:0] ret_addr;
    logic            halted;
    logic            fault;
    logic [SPW-1:0]  sp;
    logic [31:0]     icount;

    modport master (
        output en, Opcode, z, pc_next,
        input  s_inc, s_inm, we3, wez, Op, pc_we, s_ret,
        input  ret_addr, halted, fault, sp, icount
    );

    modport slave (
        input  en, Opcode, z, pc_next,
        output s_inc, s_inm, we3, wez, Op, pc_we, s_ret,
        output ret_addr, halted, fault, sp, icount
    );
endinterface

// File: rtl/uc_microc_param_pila_retorno.sv
// Return-address stack for jal/ret; push/pop are ignored when full/empty.
module pila_retorno #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    parameter int SPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic [SPW-1:0]  sp,
    output logic            full,
    output logic            empty
);

    logic [PC_W-1:0] mem_q [STACK_DEPTH];
    logic [SPW-1:0]  sp_q;
    logic [SPW-1:0]  sp_d;

    assign full  = (sp_q == SPW'(STACK_DEPTH));
    assign empty = (sp_q == '0);
    assign sp    = sp_q;

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // contents need no reset: only entries below sp are ever visible
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && !full && sp_q == SPW'(i)) begin
                mem_q[i] <= din;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) begin
                top = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/uc_microc_param.sv
// microc sequential control unit: decode, return stack, HALT/FAULT states.
// Define UC_ICOUNT_EN to build the retired-instruction counter.
module uc_microc_param
    import microc_pkg::*;
#(
    parameter int OPW         = 6,
    parameter int ALUW        = 3,
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    uc_microc_param_if.slave  bus
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);

    state_t          state_q;
    state_t          state_d;
    logic [5:0]      op6;
    logic            go;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [PC_W-1:0] top;
    logic [SPW-1:0]  sp;

    logic is_alu, is_nop, is_li, is_j, is_jz, is_jnz;
    logic is_jal, is_ret, is_halt, is_illegal;

    assign op6 = bus.Opcode[OPW-1 -: 6];
    assign go  = (state_q == RUN) && bus.en;

    assign is_alu  = (op6[5] == OP_ALU_PFX);
    assign is_nop  = (op6 == OP_NOP);
    assign is_li   = is_li_op(op6);
    assign is_j    = (op6 == OP_J);
    assign is_jz   = (op6 == OP_JZ);
    assign is_jnz  = (op6 == OP_JNZ);
    assign is_jal  = (op6 == OP_JAL);
    assign is_ret  = (op6 == OP_RET);
    assign is_halt = (op6 == OP_HALT);
    assign is_illegal = ~|{is_alu, is_nop, is_li, is_j, is_jz,
                           is_jnz, is_jal, is_ret, is_halt};

    pila_retorno #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH),
        .SPW         (SPW)
    ) u_pila (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.pc_next),
        .top   (top),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (go) begin
            unique case (1'b1)
                is_halt:         state_d = HALT;
                is_illegal:      state_d = FAULT;
                is_jal && full:  state_d = FAULT;
                is_ret && empty: state_d = FAULT;
                default:         state_d = state_q;
            endcase
        end
    end

    // mux selects follow decode in any state; every write is gated by go
    always_comb begin
        bus.s_inc = 1'b0;
        bus.s_inm = 1'b0;
        bus.we3   = 1'b0;
        bus.wez   = 1'b0;
        bus.Op    = '0;
        bus.pc_we = 1'b0;
        bus.s_ret = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        unique case (1'b1)
            is_alu: begin
                bus.s_inc = 1'b1;
                bus.Op    = bus.Opcode[ALUW+1:2];
                bus.we3   = go;
                bus.wez   = go;
                bus.pc_we = go;
            end
            is_nop: begin
                bus.s_inc = 1'b1;
                bus.pc_we = go;
            end
            is_li: begin
                bus.s_inc = 1'b1;
                bus.s_inm = 1'b1;
                bus.we3   = go;
                bus.pc_we = go;
            end
            is_j: begin
                bus.pc_we = go;
            end
            is_jz: begin
                bus.s_inc = ~bus.z;
                bus.pc_we = go;
            end
            is_jnz: begin
                bus.s_inc = bus.z;
                bus.pc_we = go;
            end
            is_jal: begin
                bus.pc_we = go && !full;
                push      = go && !full;
            end
            is_ret: begin
                bus.pc_we = go && !empty;
                bus.s_ret = go && !empty;
                pop       = go && !empty;
            end
            default: begin
                bus.pc_we = 1'b0;
            end
        endcase
    end

    assign bus.ret_addr = top;
    assign bus.sp       = sp;
    assign bus.halted   = (state_q == HALT);
    assign bus.fault    = (state_q == FAULT);

`ifdef UC_ICOUNT_EN
    logic [31:0] icount_q;
    logic [31:0] icount_d;

    assign icount_d = icount_q + (bus.pc_we ? 32'd1 : 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            icount_q <= '0;
        end else begin
            icount_q <= icount_d;
        end
    end

    assign bus.icount = icount_q;
`else
    assign bus.icount = '0;
`endif

endmodule

// File: tb/tb_uc_microc_param.sv
// Bench for uc_microc_param: decode table, directed stack/state sequences,
// and randomized traffic against a queue-based reference model.
module tb_uc_microc_param;

    localparam int OPW   = 6;
    localparam int ALUW  = 3;
    localparam int PC_W  = 10;
    localparam int DEPTH = 4;

`ifdef UC_ICOUNT_EN
    localparam bit ICNT_ON = 1'b1;
`else
    localparam bit ICNT_ON = 1'b0;
`endif

    localparam logic [5:0] ALU  = 6'b100100;
    localparam logic [5:0] NOP  = 6'b000000;
    localparam logic [5:0] LI   = 6'b000110;
    localparam logic [5:0] J    = 6'b010000;
    localparam logic [5:0] JZ   = 6'b010001;
    localparam logic [5:0] JNZ  = 6'b010010;
    localparam logic [5:0] JAL  = 6'b010011;
    localparam logic [5:0] RET  = 6'b010100;
    localparam logic [5:0] HLT  = 6'b011111;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uc_microc_param_if #(
        .OPW(OPW), .ALUW(ALUW), .PC_W(PC_W), .STACK_DEPTH(DEPTH)
    ) bus ();

    uc_microc_param #(
        .OPW(OPW), .ALUW(ALUW), .PC_W(PC_W), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        s_inc;
        logic        s_inm;
        logic        we3;
        logic        wez;
        logic [2:0]  op;
        logic        pc_we;
        logic        s_ret;
        logic [9:0]  ret_addr;
        logic        halted;
        logic        fault;
        logic [2:0]  sp;
        logic [31:0] icount;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       en;
        logic [8:0] exp;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: 0 = running, 1 = halted, 2 = faulted
    int          m_state = 0;
    logic [9:0]  m_stk[$];
    logic [31:0] m_icnt = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op[5] || op == NOP || op[5:2] == 4'b0001 ||
               (op >= J && op <= RET) || op == HLT;
    endfunction

    function automatic out_t model_out(input logic [5:0] op,
                                       input logic z, input logic en);
        out_t o;
        bit   ok;
        int   n;
        o = '0;
        n = m_stk.size();
        casez (op)
            6'b1?????: begin o.s_inc = 1'b1; o.op = op[4:2]; end
            6'b000000: o.s_inc = 1'b1;
            6'b0001??: begin o.s_inc = 1'b1; o.s_inm = 1'b1; end
            6'b010001: o.s_inc = ~z;
            6'b010010: o.s_inc = z;
            default:   o.s_inc = 1'b0;
        endcase
        ok = m_state == 0 && en && legal(op) && op != HLT &&
             !(op == JAL && n == DEPTH) && !(op == RET && n == 0);
        o.pc_we    = ok;
        o.we3      = ok && (op[5] || op[5:2] == 4'b0001);
        o.wez      = ok && op[5];
        o.s_ret    = ok && op == RET;
        o.ret_addr = (n > 0) ? m_stk[n-1] : 10'd0;
        o.halted   = m_state == 1;
        o.fault    = m_state == 2;
        o.sp       = 3'(n);
        o.icount   = ICNT_ON ? m_icnt : 32'd0;
        return o;
    endfunction

    task automatic model_step(input logic [5:0] op, input logic en,
                              input logic [9:0] pcn, input logic rst);
        if (rst) begin
            m_state = 0;
            m_stk.delete();
            m_icnt = '0;
        end else if (m_state == 0 && en) begin
            if (!legal(op)) m_state = 2;
            else if (op == HLT) m_state = 1;
            else if (op == JAL) begin
                if (m_stk.size() == DEPTH) m_state = 2;
                else begin m_stk.push_back(pcn); m_icnt++; end
            end else if (op == RET) begin
                if (m_stk.size() == 0) m_state = 2;
                else begin void'(m_stk.pop_back()); m_icnt++; end
            end else m_icnt++;
        end
    endtask

    function automatic out_t act_out();
        out_t o;
        o.s_inc    = bus.s_inc;
        o.s_inm    = bus.s_inm;
        o.we3      = bus.we3;
        o.wez      = bus.wez;
        o.op       = bus.Op;
        o.pc_we    = bus.pc_we;
        o.s_ret    = bus.s_ret;
        o.ret_addr = bus.ret_addr;
        o.halted   = bus.halted;
        o.fault    = bus.fault;
        o.sp       = bus.sp;
        o.icount   = bus.icount;
        return o;
    endfunction

    // drive right after a rising edge, compare against the model at the
    // falling edge; tick() then commits the edge to the model
    task automatic drive(input logic [5:0] op, input logic z,
                         input logic en, input logic [9:0] pcn,
                         input logic rst);
        out_t e;
        out_t a;
        bus.Opcode  = op;
        bus.z       = z;
        bus.en      = en;
        bus.pc_next = pcn;
        reset       = rst;
        @(negedge clk);
        e = model_out(op, z, en);
        a = act_out();
        if (m_state != 0) begin
            e.s_inc = 0; e.s_inm = 0; e.op = 0;
            a.s_inc = 0; a.s_inm = 0; a.op = 0;
        end
        check("model", 64'(a), 64'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(bus.Opcode, bus.en, bus.pc_next, reset);
        #1;
    endtask

    task automatic do_reset();
        repeat (2) begin
            drive(NOP, 1'b0, 1'b0, 10'd0, 1'b1);
            tick();
        end
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ill[4];
        int k;
        ill = '{6'h08, 6'h15, 6'h1e, 6'h01};
        k = $urandom_range(0, 19);
        if (k < 5)       return {1'b1, 5'($urandom)};
        else if (k == 5) return NOP;
        else if (k < 8)  return {4'b0001, 2'($urandom)};
        else if (k == 8) return J;
        else if (k == 9) return JZ;
        else if (k == 10) return JNZ;
        else if (k < 15) return JAL;
        else if (k < 18) return RET;
        else if (k == 18) return HLT;
        return ill[$urandom_range(0, 3)];
    endfunction

    initial begin
        vec_t tbl[10];
        logic rst;

        // exp = {s_inc, s_inm, we3, wez, Op[2:0], pc_we, 1'b0}
        tbl[0] = '{ALU,        1'b0, 1'b1, 9'b1011_001_1_0};
        tbl[1] = '{6'b111111,  1'b1, 1'b1, 9'b1011_111_1_0};
        tbl[2] = '{NOP,        1'b0, 1'b1, 9'b1000_000_1_0};
        tbl[3] = '{LI,         1'b0, 1'b1, 9'b1110_000_1_0};
        tbl[4] = '{J,          1'b1, 1'b1, 9'b0000_000_1_0};
        tbl[5] = '{JZ,         1'b1, 1'b1, 9'b0000_000_1_0};
        tbl[6] = '{JZ,         1'b0, 1'b1, 9'b1000_000_1_0};
        tbl[7] = '{JNZ,        1'b1, 1'b1, 9'b1000_000_1_0};
        tbl[8] = '{JNZ,        1'b0, 1'b1, 9'b0000_000_1_0};
        tbl[9] = '{LI,         1'b0, 1'b0, 9'b1100_000_0_0};

        reset = 1'b1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].op, tbl[i].z, tbl[i].en, 10'h3ff, 1'b0);
            if (i == 0)
                check("reset_state",
                      64'({bus.halted, bus.fault, bus.sp, bus.icount}), 64'd0);
            check($sformatf("table%0d", i),
                  64'({bus.s_inc, bus.s_inm, bus.we3, bus.wez,
                       bus.Op, bus.pc_we, 1'b0}), 64'(tbl[i].exp));
            tick();
        end
        drive(NOP, 1'b0, 1'b0, 10'd0, 1'b0);
        check("stall_keeps", 64'({bus.halted, bus.fault, bus.sp}), 64'd0);
        tick();

        do_reset();
        drive(JAL, 1'b0, 1'b1, 10'h005, 1'b0);
        tick();
        drive(JAL, 1'b0, 1'b1, 10'h0A1, 1'b0);
        tick();
        drive(RET, 1'b0, 1'b1, 10'h000, 1'b0);
        check("jal2_sp", 64'(bus.sp), 64'd2);
        check("ret_sret", 64'({bus.s_ret, bus.ret_addr}), 64'h4A1);
        tick();
        drive(NOP, 1'b0, 1'b1, 10'h000, 1'b0);
        check("ret_pop", 64'({bus.sp, bus.ret_addr}), {54'd0, 3'd1, 10'h005} >> 0);
        tick();

        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(JAL, 1'b0, 1'b1, 10'(i + 1), 1'b0);
            tick();
        end
        drive(JAL, 1'b0, 1'b1, 10'h3ff, 1'b0);
        check("ovf_pcwe", 64'({bus.sp, bus.pc_we, bus.fault}), 64'b100_0_0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(ALU, 1'b0, 1'b1, 10'h000, 1'b0);
            check("ovf_fault", 64'({bus.sp, bus.fault, bus.pc_we, bus.we3}),
                  64'b100_1_0_0);
            tick();
        end
        do_reset();
        drive(NOP, 1'b0, 1'b1, 10'h000, 1'b0);
        check("fault_reset", 64'({bus.fault, bus.halted, bus.sp}), 64'd0);
        tick();

        do_reset();
        drive(RET, 1'b0, 1'b1, 10'h000, 1'b0);
        check("udf_pcwe", 64'({bus.pc_we, bus.s_ret}), 64'd0);
        tick();
        drive(NOP, 1'b0, 1'b1, 10'h000, 1'b0);
        check("udf_fault", 64'(bus.fault), 64'd1);
        tick();

        do_reset();
        drive(6'b001000, 1'b0, 1'b1, 10'h000, 1'b0);
        tick();
        drive(NOP, 1'b0, 1'b1, 10'h000, 1'b0);
        check("illegal_fault", 64'({bus.fault, bus.halted}), 64'b10);
        tick();

        do_reset();
        drive(HLT, 1'b0, 1'b1, 10'h000, 1'b0);
        check("halt_pcwe", 64'(bus.pc_we), 64'd0);
        tick();
        drive(ALU, 1'b0, 1'b1, 10'h000, 1'b0);
        check("halt_hold", 64'({bus.halted, bus.fault, bus.we3, bus.pc_we}),
              64'b1000);
        tick();

        do_reset();
        drive(JAL, 1'b0, 1'b1, 10'h011, 1'b0);
        tick();
        drive(JAL, 1'b0, 1'b1, 10'h022, 1'b1);
        tick();
        drive(NOP, 1'b0, 1'b0, 10'h000, 1'b0);
        check("rst_prio", 64'({bus.sp, bus.ret_addr}), 64'd0);
        tick();

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive((i % 2) ? ALU : NOP, 1'b0, 1'b1, 10'h000, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(LI, 1'b0, 1'b0, 10'h000, 1'b0);
            tick();
        end
        drive(NOP, 1'b0, 1'b0, 10'h000, 1'b0);
        check("icount", 64'(bus.icount), ICNT_ON ? 64'd10 : 64'd0);
        tick();

        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = (m_state != 0 && $urandom_range(0, 3) == 0) ||
                  $urandom_range(0, 49) == 0;
            drive(rand_op(), 1'($urandom), $urandom_range(0, 4) != 0,
                  10'($urandom), rst);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
